// File: rtl/cpu_stack_pkg.sv
// Shared definitions for the hardware-stack PC save/restore logic:
// sequencer states, default stack page and the byte order of push/pull frames.
package cpu_stack_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PUSH_HI,
        ST_PUSH_LO,
        ST_PUSH_P,
        ST_PULL_P,
        ST_PULL_LO,
        ST_PULL_HI,
        ST_FINISH
    } stack_seq_state_t;

    typedef enum logic [1:0] {
        BSEL_PCH,
        BSEL_PCL,
        BSEL_P
    } byte_sel_t;

    localparam logic [7:0] STACK_PAGE_DEFAULT = 8'h01;

    // Push writes PC high first so that a pull (reverse order) restores it last.
    localparam byte_sel_t PUSH_BYTE0 = BSEL_PCH;
    localparam byte_sel_t PUSH_BYTE1 = BSEL_PCL;
    localparam byte_sel_t PUSH_BYTE2 = BSEL_P;
    localparam byte_sel_t PULL_BYTE0 = BSEL_P;
    localparam byte_sel_t PULL_BYTE1 = BSEL_PCL;
    localparam byte_sel_t PULL_BYTE2 = BSEL_PCH;

    function automatic byte_sel_t state_byte(input stack_seq_state_t s);
        case (s)
            ST_PUSH_HI: return PUSH_BYTE0;
            ST_PUSH_LO: return PUSH_BYTE1;
            ST_PUSH_P:  return PUSH_BYTE2;
            ST_PULL_P:  return PULL_BYTE0;
            ST_PULL_LO: return PULL_BYTE1;
            ST_PULL_HI: return PULL_BYTE2;
            default:    return BSEL_PCH;
        endcase
    endfunction

endpackage

// File: rtl/stack_pointer_step.sv
// 8-bit stack pointer step by one, wrapping in both directions.
module stack_pointer_step (
    input  logic       dec,
    input  logic [7:0] sp,
    output logic [7:0] sp_next
);

    always_comb begin
        if (dec)
            sp_next = sp - 8'd1;
        else
            sp_next = sp + 8'd1;
    end

endmodule

// File: rtl/stack_pc_sequencer.sv
// Multi-cycle sequencer pushing PC (and optionally P) to the stack page and
// pulling it back, with optional +1 correction of the restored PC.
module stack_pc_sequencer
    import cpu_stack_pkg::*;
#(
    parameter logic [7:0] STACK_PAGE = STACK_PAGE_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_push,
    input  logic       start_pull,
    input  logic       with_status,
    input  logic       pull_inc_pc,
    input  logic [7:0] pc_lowbyte_in,
    input  logic [7:0] pc_highbyte_in,
    input  logic [7:0] status_in,
    input  logic [7:0] sp_in,
    input  logic       mem_ready,
    input  logic [7:0] mem_rdata,
    output logic [7:0] mem_addr_low,
    output logic [7:0] mem_addr_high,
    output logic [7:0] mem_wdata,
    output logic       mem_write,
    output logic       mem_read,
    output logic [7:0] pc_lowbyte_out,
    output logic [7:0] pc_highbyte_out,
    output logic [7:0] status_out,
    output logic [7:0] sp_out,
    output logic       pc_load,
    output logic       status_load,
    output logic       busy,
    output logic       done
);

    stack_seq_state_t state, next_state;

    logic       with_status_q;
    logic       inc_q;
    logic       is_pull_q;
    logic       phase_q;       // pull: 0 = SP pre-increment cycle, 1 = read cycle
    logic [7:0] pcl_lat, pch_lat, p_lat;
    logic [7:0] sp_q;
    logic [7:0] wdata_q;
    logic [7:0] lo_cap;
    logic [7:0] pcl_q, pch_q, status_q;
    logic [7:0] sp_step;
    logic [7:0] next_wbyte;
    logic       sp_dec;

    stack_pointer_step u_sp_step (
        .dec     (sp_dec),
        .sp      (sp_q),
        .sp_next (sp_step)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state  = state;
        mem_write   = 1'b0;
        mem_read    = 1'b0;
        done        = 1'b0;
        pc_load     = 1'b0;
        status_load = 1'b0;
        sp_dec      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_push)
                    next_state = ST_PUSH_HI;
                else if (start_pull)
                    next_state = with_status ? ST_PULL_P : ST_PULL_LO;
            end
            ST_PUSH_HI: begin
                mem_write = 1'b1;
                sp_dec    = 1'b1;
                if (mem_ready) next_state = ST_PUSH_LO;
            end
            ST_PUSH_LO: begin
                mem_write = 1'b1;
                sp_dec    = 1'b1;
                if (mem_ready) next_state = with_status_q ? ST_PUSH_P : ST_FINISH;
            end
            ST_PUSH_P: begin
                mem_write = 1'b1;
                sp_dec    = 1'b1;
                if (mem_ready) next_state = ST_FINISH;
            end
            ST_PULL_P: begin
                mem_read = phase_q;
                if (phase_q && mem_ready) next_state = ST_PULL_LO;
            end
            ST_PULL_LO: begin
                mem_read = phase_q;
                if (phase_q && mem_ready) next_state = ST_PULL_HI;
            end
            ST_PULL_HI: begin
                mem_read = phase_q;
                if (phase_q && mem_ready) next_state = ST_FINISH;
            end
            ST_FINISH: begin
                done        = 1'b1;
                pc_load     = is_pull_q;
                status_load = is_pull_q && with_status_q;
                next_state  = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        next_wbyte = pch_lat;
        case (state_byte(next_state))
            BSEL_PCL: next_wbyte = pcl_lat;
            BSEL_P:   next_wbyte = p_lat;
            default:  next_wbyte = pch_lat;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            with_status_q <= 1'b0;
            inc_q         <= 1'b0;
            is_pull_q     <= 1'b0;
            phase_q       <= 1'b0;
            pcl_lat       <= '0;
            pch_lat       <= '0;
            p_lat         <= '0;
            sp_q          <= '0;
            wdata_q       <= '0;
            lo_cap        <= '0;
            pcl_q         <= '0;
            pch_q         <= '0;
            status_q      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_push || start_pull) begin
                        with_status_q <= with_status;
                        inc_q         <= pull_inc_pc;
                        is_pull_q     <= !start_push;
                        phase_q       <= 1'b0;
                        pcl_lat       <= pc_lowbyte_in;
                        pch_lat       <= pc_highbyte_in;
                        p_lat         <= status_in;
                        sp_q          <= sp_in;
                        if (start_push) wdata_q <= pc_highbyte_in;
                    end
                end
                ST_PUSH_HI, ST_PUSH_LO, ST_PUSH_P: begin
                    if (mem_ready) begin
                        sp_q <= sp_step;
                        if (next_state != ST_FINISH) wdata_q <= next_wbyte;
                    end
                end
                ST_PULL_P, ST_PULL_LO, ST_PULL_HI: begin
                    if (!phase_q) begin
                        sp_q    <= sp_step;
                        phase_q <= 1'b1;
                    end else if (mem_ready) begin
                        phase_q <= 1'b0;
                        case (state_byte(state))
                            BSEL_P:   status_q <= mem_rdata;
                            BSEL_PCL: lo_cap   <= mem_rdata;
                            default:  {pch_q, pcl_q} <= {mem_rdata, lo_cap} + {15'd0, inc_q};
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_addr_low    = sp_q;
    assign mem_addr_high   = STACK_PAGE;
    assign mem_wdata       = wdata_q;
    assign pc_lowbyte_out  = pcl_q;
    assign pc_highbyte_out = pch_q;
    assign status_out      = status_q;
    assign sp_out          = sp_q;
    assign busy            = (state != ST_IDLE);

endmodule

// File: doc/stack_pc_sequencer.md
Name: stack_pc_sequencer

Overview:
Multi-cycle sequencer that saves the program counter (PC) to the hardware stack and restores it. It is the store/restore counterpart of the PC increment/decrement logic.
- Push sequence: PC high, PC low, then optional status byte P. Used by JSR, BRK and IRQ/NMI.
- Pull sequence: optional P, PC low, then PC high, with optional +1 correction. Used by RTS and RTI.
- Sits between the control unit, the stack pointer (SP) register and the memory bus interface.

Parameters:
- STACK_PAGE, 8'h01, high address byte of every stack access.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- start_push  input  1  begin push sequence; sampled only in IDLE.
- start_pull  input  1  begin pull sequence; sampled only in IDLE.
- with_status  input  1  include P byte in the sequence; latched at start.
- pull_inc_pc  input  1  add 1 to the restored PC (RTS); latched at start.
- pc_lowbyte_in  input  8  PC low byte to push; latched at start.
- pc_highbyte_in  input  8  PC high byte to push; latched at start.
- status_in  input  8  P byte to push; latched at start.
- sp_in  input  8  current SP; latched at start.
- mem_ready  input  1  bus completes the current access this cycle.
- mem_rdata  input  8  read data; valid when mem_ready=1 on a read.
- mem_addr_low  output  8  stack address low byte (current SP).
- mem_addr_high  output  8  always STACK_PAGE.
- mem_wdata  output  8  write data.
- mem_write  output  1  write request.
- mem_read  output  1  read request.
- pc_lowbyte_out  output  8  restored PC low byte.
- pc_highbyte_out  output  8  restored PC high byte.
- status_out  output  8  restored P byte.
- sp_out  output  8  updated SP.
- pc_load  output  1  one-cycle strobe: restored PC is valid.
- status_load  output  1  one-cycle strobe: status_out is valid.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle strobe when a sequence completes.

Behaviour:
- Reset values (rst=1 at a clk edge): state=IDLE; all data/address outputs 0, except mem_addr_high=STACK_PAGE; all strobes and requests 0. Reset mid-sequence aborts immediately; no further memory request is issued.
- States: IDLE, PUSH_HI, PUSH_LO, PUSH_P, PULL_P, PULL_LO, PULL_HI, FINISH.
- Start from IDLE:
  - start_push -> PUSH_HI. start_pull -> PULL_P if with_status=1, else PULL_LO.
  - Both asserted together: push wins; pull is ignored, not queued.
  - Starts while busy are ignored.
- Push state behaviour:
  - Assert mem_write; mem_wdata = latched byte; mem_addr_low = SP.
  - Hold the request, address and data stable until mem_ready=1.
  - On the mem_ready cycle: SP <= SP-1 (0x00 wraps to 0xFF), then advance.
  - Order: PUSH_HI -> PUSH_LO -> PUSH_P (only if with_status) -> FINISH.
- Pull state behaviour:
  - On entry, SP <= SP+1 (0xFF wraps to 0x00). This pre-increment takes one cycle with no request asserted.
  - Then assert mem_read with mem_addr_low = incremented SP.
  - Capture mem_rdata on the mem_ready cycle, then advance.
  - Order: PULL_P -> PULL_LO -> PULL_HI -> FINISH.
- FINISH (one cycle):
  - done=1; sp_out holds the final SP; return to IDLE.
  - Pull only: pc_load=1 with restored PC = {hi,lo} + pull_inc_pc, 16-bit wrap (0xFFFF+1 = 0x0000).
  - Pull with status: status_load=1.
- Latency with mem_ready tied high:
  - Push: 2 or 3 access cycles + FINISH.
  - Pull: 2 cycles per byte (pre-increment + read) + FINISH.
- mem_read and mem_write are never high in the same cycle.
- Outputs hold their last values while in IDLE.

Decomposition:
- Shared package cpu_stack_pkg holds:
  - the state enum stack_seq_state_t;
  - constant STACK_PAGE_DEFAULT = 8'h01;
  - the push/pull byte-order constants.
- One natural sub-module, stack_pointer_step: 8-bit SP ±1 with wrap, combinational. Reused by the CPU SP register logic.

Test Plan:
- Push, no status, mem_ready=1: SP=0xFD, PC=0x1234 -> write 0x12 @0x01FD, then 0x34 @0x01FC; done; sp_out=0xFB.
- Push with status: SP=0x00, PC=0xABCD, P=0x24 -> writes @0x0100, @0x01FF, @0x01FE; sp_out=0xFD.
- RTS pull: SP=0xFB, memory 0x01FC=0x33, 0x01FD=0x12, pull_inc_pc=1 -> pc_load with PC=0x1234; sp_out=0xFD.
- RTI pull with PC wrap: SP=0xFC, memory 0x01FD=0x24, 0x01FE=0xFF, 0x01FF=0xFF, pull_inc_pc=1 -> status_out=0x24; PC=0x0000; sp_out=0xFF.
- Bus stall and reset:
  - mem_ready low for 3 cycles during PUSH_LO -> address, data and request stay stable; SP unchanged until ready.
  - Assert rst mid-pull -> IDLE next cycle; no pc_load.
- Simultaneous start_push and start_pull in IDLE -> push executes. start_pull while busy -> ignored; exactly one done.
